// File: rtl/obuft_bus_arbiter.sv
// obuft_bus_arbiter: round-robin owner of a shared OBUFT pad bus with bounded hold and Hi-Z turnaround
module obuft_bus_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16,
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   C,
  input  logic                   R,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*WIDTH-1:0] DIN,
  output logic [N_REQ-1:0]       GNT,
  output logic [WIDTH-1:0]       O_BUS,
  output logic [WIDTH-1:0]       T_BUS,
  output logic [OW-1:0]          OWNER,
  output logic                   BUSY
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;
  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;
  state_t           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [WIDTH-1:0] o_q;
  logic             hiz_q;
  logic [OW-1:0]    owner_q, ptr_q, pick, nxt;
  logic [HW-1:0]    hc_q;
  logic [TW-1:0]    tc_q;
  logic [N_REQ-1:0] others;
  logic             rel;
  int               k;
  // lowest rotational offset from ptr_q wins, so scan offsets downward
  always_comb begin
    pick = ptr_q;
    k = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr_q) + i) % N_REQ;
      if (REQ[k]) pick = OW'(k);
    end
  end
  always_comb begin
    others = REQ;
    others[owner_q] = 1'b0;
    rel = !REQ[owner_q] || (hc_q == HW'(MAX_HOLD) && |others);
    nxt = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  end
  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      hiz_q   <= 1'b1;
      o_q     <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hc_q    <= '0;
      tc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (|REQ) begin
          state_q <= DRIVE;
          gnt_q   <= N_REQ'(1) << pick;
          hiz_q   <= 1'b0;
          owner_q <= pick;
          o_q     <= DIN[pick*WIDTH +: WIDTH];
          hc_q    <= HW'(1);
        end
        DRIVE: if (rel) begin
          state_q <= (TURN_CYC == 0) ? IDLE : TURN;
          gnt_q   <= '0;
          hiz_q   <= 1'b1;
          ptr_q   <= nxt;
          tc_q    <= TW'(TURN_CYC);
        end else begin
          o_q <= DIN[owner_q*WIDTH +: WIDTH];
          if (hc_q != HW'(MAX_HOLD)) hc_q <= hc_q + 1'b1;
        end
        TURN: begin
          tc_q <= tc_q - 1'b1;
          if (tc_q == TW'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign GNT   = gnt_q;
  assign O_BUS = o_q;
  assign T_BUS = {WIDTH{hiz_q}};
  assign OWNER = owner_q;
  assign BUSY  = state_q != IDLE;
endmodule

// File: tb/tb_obuft_bus_arbiter.sv
// tb_obuft_bus_arbiter: three builds (defaults, short hold, no turnaround) against a cycle-level model
module tb_obuft_bus_arbiter;
  logic        clk = 1'b0;
  logic        R = 1'b1;
  logic [3:0]  REQ = '0;
  logic [31:0] DIN = '0;
  logic [3:0]  gnt  [3];
  logic [7:0]  ob   [3];
  logic [7:0]  tbus [3];
  logic [1:0]  own  [3];
  logic        busy [3];
  int n_chk = 0, n_pass = 0;
  int mh  [3] = '{16, 4, 4};
  int tcy [3] = '{1, 1, 0};
  typedef struct {
    bit         drv;
    int         gap, own, ptr, hold;
    logic [7:0] o;
  } mdl_t;
  mdl_t md [3];
  always #5 clk = ~clk;
  obuft_bus_arbiter dut0 (.C(clk), .R(R), .REQ(REQ), .DIN(DIN), .GNT(gnt[0]), .O_BUS(ob[0]),
    .T_BUS(tbus[0]), .OWNER(own[0]), .BUSY(busy[0]));
  obuft_bus_arbiter #(.MAX_HOLD(4), .TURN_CYC(1)) dut1 (.C(clk), .R(R), .REQ(REQ), .DIN(DIN),
    .GNT(gnt[1]), .O_BUS(ob[1]), .T_BUS(tbus[1]), .OWNER(own[1]), .BUSY(busy[1]));
  obuft_bus_arbiter #(.MAX_HOLD(4), .TURN_CYC(0)) dut2 (.C(clk), .R(R), .REQ(REQ), .DIN(DIN),
    .GNT(gnt[2]), .O_BUS(ob[2]), .T_BUS(tbus[2]), .OWNER(own[2]), .BUSY(busy[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask
  function automatic mdl_t step(input mdl_t s, input logic r, input logic [3:0] q,
                                input logic [31:0] d, input int hmax, input int turn);
    mdl_t n = s;
    logic [3:0] oth;
    int k;
    if (r) begin
      n = '{drv: 0, gap: 0, own: 0, ptr: 0, hold: 0, o: 8'h00};
    end else if (s.drv) begin
      oth = q;
      oth[s.own] = 1'b0;
      if (!q[s.own] || (s.hold >= hmax && oth != 0)) begin
        n.drv = 0;
        n.ptr = (s.own + 1) % 4;
        n.gap = turn;
      end else begin
        n.o = d[s.own*8 +: 8];
        n.hold = (s.hold < hmax) ? s.hold + 1 : hmax;
      end
    end else if (s.gap > 0) begin
      n.gap = s.gap - 1;
    end else if (q != 0) begin
      for (int i = 0; i < 4; i++) begin
        k = (s.ptr + i) % 4;
        if (q[k]) begin
          n.own = k;
          break;
        end
      end
      n.drv = 1;
      n.hold = 1;
      n.o = d[n.own*8 +: 8];
    end
    return n;
  endfunction
  task automatic cyc(input logic r, input logic [3:0] q);
    R = r;
    REQ = q;
    DIN = $urandom;
    @(posedge clk);
    for (int m = 0; m < 3; m++) md[m] = step(md[m], r, q, DIN, mh[m], tcy[m]);
    #1;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("gnt%0d", m), 32'(gnt[m]), md[m].drv ? 32'(1) << md[m].own : 32'd0);
      chk($sformatf("tbus%0d", m), 32'(tbus[m]), md[m].drv ? 32'h00 : 32'hFF);
      chk($sformatf("obus%0d", m), 32'(ob[m]), 32'(md[m].o));
      chk($sformatf("owner%0d", m), 32'(own[m]), 32'(md[m].own));
      chk($sformatf("busy%0d", m), 32'(busy[m]), 32'(md[m].drv || md[m].gap > 0));
      chk($sformatf("onehot%0d", m), 32'($onehot0(gnt[m])), 32'd1);
      chk($sformatf("t_vs_gnt%0d", m), 32'(tbus[m] == 8'h00), 32'(gnt[m] != 4'd0));
    end
  endtask
  initial begin
    logic [3:0] q;
    for (int m = 0; m < 3; m++) md[m] = '{drv: 0, gap: 0, own: 0, ptr: 0, hold: 0, o: 8'h00};
    repeat (2) cyc(1'b1, 4'b1111);
    repeat (4) cyc(1'b0, 4'b1111);
    cyc(1'b1, 4'b0000);
    repeat (3) cyc(1'b0, 4'b0000);
    repeat (5) cyc(1'b0, 4'b0100);
    repeat (4) cyc(1'b0, 4'b0000);
    repeat (60) cyc(1'b0, 4'b1111);
    cyc(1'b1, 4'b0000);
    repeat (40) cyc(1'b0, 4'b0010);
    repeat (20) cyc(1'b0, 4'b1010);
    repeat (4) cyc(1'b0, 4'b0000);
    repeat (5) cyc(1'b0, 4'b0100);
    cyc(1'b1, 4'b1111);
    repeat (6) cyc(1'b0, 4'b1111);
    repeat (30) cyc(1'b0, 4'b0101);
    q = 4'b0000;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) q[$urandom_range(0, 3)] ^= 1'b1;
      cyc($urandom_range(0, 199) == 0, q);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
